// File: rtl/channel_err_inj.sv
// channel_err_inj: corrupts a stream of 2-bit convolutional-encoder symbols
// on their way to a decoder, so the decoder's error correction can be exercised.
//
// Modes (mode_i):
//   00 = pass through unchanged
//   01 = periodic: invert one symbol in every 2**PERIOD_LOG2
//   10 = burst:    invert BURST_LEN consecutive symbols, once per period
//   11 = random:   invert a symbol when an LFSR draw falls below thresh_i
// Only the first WINDOW symbols may start a corruption.
// A burst that has already started is allowed to run on past WINDOW.
//
// Ports:
//   clk          - sole clock; all state updates on its rising edge
//   rst          - asynchronous active-low reset
//   mode_i       - injection mode (see above)
//   err_mask_i   - bits to invert in periodic/burst (and random, if non-zero)
//   thresh_i     - random-mode injection threshold
//   valid_i      - d_in carries a symbol this cycle
//   d_in         - encoder symbol {g1,g0}
//   valid_o      - valid_i delayed by one cycle; drives the decoder enable
//   d_out        - possibly corrupted symbol, one cycle after d_in
//   inj_o        - d_out carries a non-zero mask
//   word_ct_o    - accepted symbols (saturating)
//   bad_bit_ct_o - inverted bits (saturating)
module channel_err_inj #(
    parameter int          PERIOD_LOG2 = 4,
    parameter int          WINDOW      = 256,
    parameter int          BURST_LEN   = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode_i,
    input  logic [1:0]  err_mask_i,
    input  logic [7:0]  thresh_i,
    input  logic        valid_i,
    input  logic [1:0]  d_in,
    output logic        valid_o,
    output logic [1:0]  d_out,
    output logic        inj_o,
    output logic [15:0] word_ct_o,
    output logic [15:0] bad_bit_ct_o
);

    // The counter width holds BURST_LEN up to 2**PERIOD_LOG2.
    localparam int             CW         = PERIOD_LOG2 + 1;
    localparam logic [CW-1:0]  BURST_LOAD = CW'(BURST_LEN - 1);
    localparam logic [16:0]    WIN_LIM    = 17'(WINDOW);
    // An all-zero LFSR would stay at zero forever, so a zero seed becomes 1.
    localparam logic [15:0]    LFSR_INIT  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [1:0] {
        MODE_PASS     = 2'b00,
        MODE_PERIODIC = 2'b01,
        MODE_BURST    = 2'b10,
        MODE_RANDOM   = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   burst_ct_q, burst_ct_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic            valid_q, valid_d;
    logic [1:0]      d_out_q, d_out_d;
    logic            inj_q, inj_d;
    logic [15:0]     word_ct_q, word_ct_d;
    logic [15:0]     bad_bit_ct_q, bad_bit_ct_d;

    logic            eligible;
    logic            trigger;
    logic [1:0]      mask;
    logic [1:0]      rnd_mask;
    logic [1:0]      pop;
    logic [16:0]     bad_sum;
    logic            lfsr_fb;

    always_comb begin
        state_d      = state_q;
        burst_ct_d   = burst_ct_q;
        lfsr_d       = lfsr_q;
        valid_d      = valid_i;
        d_out_d      = d_out_q;
        inj_d        = 1'b0;
        word_ct_d    = word_ct_q;
        bad_bit_ct_d = bad_bit_ct_q;
        mask         = 2'b00;

        // Eligibility and triggers use the count before this symbol is added.
        eligible = ({1'b0, word_ct_q} < WIN_LIM);
        trigger  = eligible && (&word_ct_q[PERIOD_LOG2-1:0]);

        // x^16+x^14+x^13+x^11+1, shifted left with feedback into bit 0
        lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

        // Random mode prefers the user mask; otherwise it uses two LFSR bits,
        // and never the all-zero mask.
        if (err_mask_i != 2'b00)
            rnd_mask = err_mask_i;
        else if (lfsr_q[9:8] != 2'b00)
            rnd_mask = lfsr_q[9:8];
        else
            rnd_mask = 2'b11;

        // Leaving burst mode aborts any burst in progress, even when no symbol
        // arrives in that cycle.
        if (mode_e'(mode_i) != MODE_BURST) begin
            state_d    = ST_IDLE;
            burst_ct_d = '0;
        end

        if (valid_i) begin
            case (mode_e'(mode_i))
                MODE_PASS: ;
                MODE_PERIODIC: begin
                    if (trigger) mask = err_mask_i;
                end
                MODE_BURST: begin
                    if (state_q == ST_BURST) begin
                        mask       = err_mask_i;
                        burst_ct_d = burst_ct_q - 1'b1;
                        if (burst_ct_q == CW'(1)) state_d = ST_IDLE;
                    end else if (trigger) begin
                        mask = err_mask_i;
                        if (BURST_LOAD != '0) begin
                            burst_ct_d = BURST_LOAD;
                            state_d    = ST_BURST;
                        end
                    end
                end
                MODE_RANDOM: begin
                    if (eligible && (lfsr_q[7:0] < thresh_i)) mask = rnd_mask;
                end
            endcase

            d_out_d = d_in ^ mask;
            inj_d   = |mask;
            lfsr_d  = {lfsr_q[14:0], lfsr_fb};

            if (word_ct_q != '1) word_ct_d = word_ct_q + 1'b1;
        end

        pop     = {1'b0, mask[1]} + {1'b0, mask[0]};
        bad_sum = {1'b0, bad_bit_ct_q} + {15'b0, pop};
        if (valid_i) bad_bit_ct_d = bad_sum[16] ? '1 : bad_sum[15:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            burst_ct_q   <= '0;
            lfsr_q       <= LFSR_INIT;
            valid_q      <= 1'b0;
            d_out_q      <= '0;
            inj_q        <= 1'b0;
            word_ct_q    <= '0;
            bad_bit_ct_q <= '0;
        end else begin
            state_q      <= state_d;
            burst_ct_q   <= burst_ct_d;
            lfsr_q       <= lfsr_d;
            valid_q      <= valid_d;
            d_out_q      <= d_out_d;
            inj_q        <= inj_d;
            word_ct_q    <= word_ct_d;
            bad_bit_ct_q <= bad_bit_ct_d;
        end
    end

    assign valid_o      = valid_q;
    assign d_out        = d_out_q;
    assign inj_o        = inj_q;
    assign word_ct_o    = word_ct_q;
    assign bad_bit_ct_o = bad_bit_ct_q;

endmodule

// File: tb/tb_channel_err_inj.sv
// Directed bench for channel_err_inj with default parameters.
module tb_channel_err_inj;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  mode_i = 2'b00;
    logic [1:0]  err_mask_i = 2'b00;
    logic [7:0]  thresh_i = 8'd0;
    logic        valid_i = 1'b0;
    logic [1:0]  d_in = 2'b00;
    logic        valid_o;
    logic [1:0]  d_out;
    logic        inj_o;
    logic [15:0] word_ct_o;
    logic [15:0] bad_bit_ct_o;

    int n_vec = 0;
    int n_err = 0;

    channel_err_inj #(
        .PERIOD_LOG2 (4),
        .WINDOW      (256),
        .BURST_LEN   (3),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode_i       (mode_i),
        .err_mask_i   (err_mask_i),
        .thresh_i     (thresh_i),
        .valid_i      (valid_i),
        .d_in         (d_in),
        .valid_o      (valid_o),
        .d_out        (d_out),
        .inj_o        (inj_o),
        .word_ct_o    (word_ct_o),
        .bad_bit_ct_o (bad_bit_ct_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one input vector, let it be clocked in, sample 1 time unit later.
    task automatic step(input logic v, input logic [1:0] d);
        valid_i = v;
        d_in    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        valid_i = 1'b0;
        rst     = 1'b0;
        #1;
        chk({tag, "_valid"}, 32'(valid_o), 32'd0);
        chk({tag, "_dout"},  32'(d_out),   32'd0);
        chk({tag, "_inj"},   32'(inj_o),   32'd0);
        chk({tag, "_word"},  32'(word_ct_o), 32'd0);
        chk({tag, "_bad"},   32'(bad_bit_ct_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        return {s[14:0], ^(s & 16'hB400)};
    endfunction

    initial begin
        logic        e_inj;
        logic [1:0]  e_mask;
        logic [1:0]  e_d;
        logic [15:0] m;
        int          acc;
        int          off;

        do_reset("rst0");

        // Periodic, mask 01, d_in=10: words 15,31,...,255 become 11.
        mode_i = 2'b01; err_mask_i = 2'b01;
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 2'b10);
            e_inj = (i < 256) && (i % 16 == 15);
            chk("per_inj",  32'(inj_o), 32'(e_inj));
            chk("per_dout", 32'(d_out), e_inj ? 32'h3 : 32'h2);
        end
        chk("per_valid", 32'(valid_o), 32'd1);
        chk("per_word",  32'(word_ct_o), 32'd300);
        chk("per_bad",   32'(bad_bit_ct_o), 32'd16);

        // Burst, mask 11: triggers at 15,31,...,255, three symbols each.
        do_reset("rst1");
        mode_i = 2'b10; err_mask_i = 2'b11;
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 2'b00);
            off   = (i >= 15) ? (i - 15) % 16 : 99;
            e_inj = (off < 3) && ((i - off) < 256);
            chk("bst_inj",  32'(inj_o), 32'(e_inj));
            chk("bst_dout", 32'(d_out), e_inj ? 32'h3 : 32'h0);
        end
        chk("bst_word", 32'(word_ct_o), 32'd300);
        chk("bst_bad",  32'(bad_bit_ct_o), 32'd96);

        // Random: thresh 0 never injects; thresh 255 follows the LFSR.
        do_reset("rst2");
        m = 16'hACE1;
        mode_i = 2'b11; err_mask_i = 2'b00; thresh_i = 8'd0;
        for (int i = 0; i < 20; i++) begin
            e_d = 2'(i);
            step(1'b1, e_d);
            chk("rnd0_inj",  32'(inj_o), 32'd0);
            chk("rnd0_dout", 32'(d_out), 32'(e_d));
            m = lfsr_adv(m);
        end
        thresh_i = 8'd255;
        for (int i = 0; i < 60; i++) begin
            if (i == 40) err_mask_i = 2'b10;
            e_d = 2'(i * 3);
            if (m[7:0] < 8'd255)
                e_mask = (err_mask_i != 2'b00) ? err_mask_i :
                         (m[9:8] != 2'b00) ? m[9:8] : 2'b11;
            else
                e_mask = 2'b00;
            step(1'b1, e_d);
            chk("rnd_inj",  32'(inj_o), 32'(e_mask != 2'b00));
            chk("rnd_dout", 32'(d_out), 32'(e_d ^ e_mask));
            m = lfsr_adv(m);
        end
        chk("rnd_word", 32'(word_ct_o), 32'd80);

        // Periodic with valid toggling: idle cycles hold d_out and counters.
        do_reset("rst3");
        mode_i = 2'b01; err_mask_i = 2'b10; thresh_i = 8'd0;
        acc = 0;
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 2'b01);
            e_inj = (acc % 16 == 15);
            e_d   = e_inj ? 2'b11 : 2'b01;
            chk("tog_inj",  32'(inj_o), 32'(e_inj));
            chk("tog_dout", 32'(d_out), 32'(e_d));
            acc++;
            step(1'b0, 2'b10);
            chk("tog_idle_valid", 32'(valid_o), 32'd0);
            chk("tog_idle_inj",   32'(inj_o),   32'd0);
            chk("tog_idle_dout",  32'(d_out),   32'(e_d));
            chk("tog_idle_word",  32'(word_ct_o), 32'(acc));
        end
        chk("tog_bad", 32'(bad_bit_ct_o), 32'd2);

        // Burst aborted by switching to pass on the second burst symbol.
        do_reset("rst4");
        mode_i = 2'b10; err_mask_i = 2'b11;
        for (int i = 0; i < 15; i++) step(1'b1, 2'b00);
        chk("sw_pre_inj", 32'(inj_o), 32'd0);
        step(1'b1, 2'b00);
        chk("sw_trig_dout", 32'(d_out), 32'h3);
        mode_i = 2'b00;
        step(1'b1, 2'b00);
        chk("sw_pass_dout", 32'(d_out), 32'h0);
        chk("sw_pass_inj",  32'(inj_o), 32'd0);
        mode_i = 2'b10;
        step(1'b1, 2'b00);
        chk("sw_idle1_inj", 32'(inj_o), 32'd0);
        step(1'b1, 2'b00);
        chk("sw_idle2_inj", 32'(inj_o), 32'd0);
        chk("sw_bad", 32'(bad_bit_ct_o), 32'd2);

        // Reset asserted in the middle of a burst.
        do_reset("rst5");
        mode_i = 2'b10; err_mask_i = 2'b11;
        for (int i = 0; i < 17; i++) step(1'b1, 2'b00);
        chk("mid_burst_dout", 32'(d_out), 32'h3);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(valid_o), 32'd0);
        chk("mid_rst_dout",  32'(d_out),   32'd0);
        chk("mid_rst_inj",   32'(inj_o),   32'd0);
        chk("mid_rst_word",  32'(word_ct_o), 32'd0);
        chk("mid_rst_bad",   32'(bad_bit_ct_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 2'b01);
        chk("post_rst_dout", 32'(d_out), 32'h1);
        chk("post_rst_inj",  32'(inj_o), 32'd0);
        chk("post_rst_word", 32'(word_ct_o), 32'd1);
        step(1'b1, 2'b01);
        chk("post_rst2_inj", 32'(inj_o), 32'd0);
        chk("post_rst2_word", 32'(word_ct_o), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/channel_err_inj.md
CHANNEL_ERR_INJ -- requirements
Module: channel_err_inj

Interface
REQ-001 SHALL have parameter PERIOD_LOG2, default 4, injection period exponent (trigger every 2**PERIOD_LOG2 symbols).
REQ-002 SHALL have parameter WINDOW, default 256, number of leading symbols eligible for injection.
REQ-003 SHALL have parameter BURST_LEN, default 3, consecutive corrupted symbols per burst (legal range 1..2**PERIOD_LOG2).
REQ-004 SHALL have parameter LFSR_SEED, default 16'hACE1, random-mode LFSR reset value; a value of 0 SHALL be replaced by 16'h0001.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port mode_i, input, 2, injection mode: 00 pass, 01 periodic, 10 burst, 11 random.
REQ-008 SHALL have port err_mask_i, input, 2, bits to invert in periodic and burst modes.
REQ-009 SHALL have port thresh_i, input, 8, random-mode injection threshold.
REQ-010 SHALL have port valid_i, input, 1, d_in carries a symbol this cycle.
REQ-011 SHALL have port d_in, input, 2, encoder symbol {g1,g0}.
REQ-012 SHALL have port valid_o, input-aligned output valid, output, 1, drives the decoder enable.
REQ-013 SHALL have port d_out, output, 2, possibly-corrupted symbol.
REQ-014 SHALL have port inj_o, output, 1, high when the current d_out carries a non-zero mask.
REQ-015 SHALL have port word_ct_o, output, 16, count of accepted symbols.
REQ-016 SHALL have port bad_bit_ct_o, output, 16, count of inverted bits.

Function
REQ-017 SHALL register outputs with a fixed latency of 1 cycle: valid_i/d_in at edge k appear on valid_o/d_out after edge k.
REQ-018 SHALL, on a cycle with valid_i=0, drive valid_o=0 and inj_o=0, hold d_out, and advance no counter, LFSR or FSM.
REQ-019 SHALL compute d_out = d_in XOR mask, where mask is 2'b00 unless injection applies to this symbol.
REQ-020 SHALL evaluate eligibility on the word_ct value before increment; a symbol is eligible only while word_ct < WINDOW.
REQ-021 SHALL increment word_ct by 1 per accepted symbol, saturating at 16'hFFFF.
REQ-022 SHALL add popcount(mask) (0, 1 or 2) to bad_bit_ct per accepted symbol, saturating at 16'hFFFF.
REQ-023 Pass mode SHALL apply mask 2'b00 always.
REQ-024 Periodic mode SHALL apply err_mask_i when eligible and word_ct[PERIOD_LOG2-1:0] is all ones.
REQ-025 Burst mode SHALL use FSM IDLE/BURST with a burst counter: in IDLE, an eligible trigger symbol (as REQ-024) applies err_mask_i, loads counter with BURST_LEN-1 and moves to BURST if that is non-zero; in BURST each accepted symbol applies err_mask_i and decrements; reaching 0 returns to IDLE.
REQ-026 Burst in progress SHALL continue past the WINDOW boundary until complete; a new burst SHALL NOT start outside the window.
REQ-027 The FSM SHALL return to IDLE with counter 0 on the first cycle mode_i != 10; the symbol in that cycle uses the new mode.
REQ-028 Random mode SHALL use a 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, shifting left, feedback into bit 0, advancing once per accepted symbol in every mode.
REQ-029 Random mode SHALL inject when eligible and lfsr[7:0] < thresh_i (current value, before advance); mask = err_mask_i if non-zero, else lfsr[9:8], and if that is 00 then 2'b11.
REQ-030 thresh_i=0 SHALL never inject; err_mask_i=00 in periodic/burst SHALL inject nothing and count nothing.

Reset
REQ-031 On rst low, asynchronously: valid_o=0, d_out=00, inj_o=0, word_ct=0, bad_bit_ct=0, FSM=IDLE, burst counter=0, LFSR=LFSR_SEED (or 1 if seed 0).
REQ-032 Reset asserted mid-burst SHALL abort the burst; after release the first accepted symbol is treated as word 0.

Verification
REQ-033 Periodic, mask 01, valid_i=1 for 300 cycles, d_in=10 -> d_out=11 with inj_o=1 on words 15,31,...,255 only; final word_ct=300, bad_bit_ct=16.
REQ-034 Burst, mask 11, BURST_LEN=3 -> words 15,16,17 and 31,32,33 ... inverted; burst at 255 completes on 256,257; bad_bit_ct=96.
REQ-035 Random, thresh_i=0 then 255 -> no injection; then injection on every symbol whose lfsr[7:0] < 255, matching a reference LFSR model.
REQ-036 valid_i toggling 1/0 in periodic mode -> injections land on the 16th, 32nd accepted symbol; idle cycles leave d_out held and counters frozen.
REQ-037 Switch mode 10->00 on the second burst symbol -> that symbol and later ones clean, FSM in IDLE.
REQ-038 Assert rst during BURST -> all outputs 0 immediately; next accepted symbol has word_ct=0 and is clean.
